// File: rtl/spongent_feeder.sv
// Initiator-side driver for the iterative SPONGENT hash core: absorbs a valid/ready word stream,
// triggers the final hash and returns the digest. Optional watchdog: SPONGENT_FEEDER_TIMEOUT_EN.
module spongent_feeder #(
  parameter int N              = 256,
  parameter int r              = 16,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [r-1:0]     msg_data,
  input  logic             msg_valid,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic             core_rst,
  output logic [r-1:0]     core_data,
  output logic             core_data_ready,
  output logic             core_start_hash,
  input  logic             core_busy,
  input  logic             core_end_hash,
  input  logic [N-1:0]     core_digest,
  output logic [N-1:0]     digest,
  output logic [CNT_W-1:0] digest_words,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             error
);

  if ((r != 8 && r != 16) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("spongent_feeder: r must be 8 or 16 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    S_CRST, S_IDLE, S_STROBE, S_HOLD, S_WAIT, S_FINAL, S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       crst_cnt_q, crst_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             last_q, last_d;
  logic             seen_busy_q, seen_busy_d;
  logic [r-1:0]     core_data_d;
  logic [N-1:0]     digest_d;
  logic [CNT_W-1:0] digest_words_d;
  logic             accept;
  logic             timeout_hit;

  // msg_ready is only ever registered high while in IDLE, so at most one word is in flight.
  assign accept = (state_q == S_IDLE) && msg_valid && msg_ready;

`ifdef SPONGENT_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            in_watch;

  assign in_watch    = (state_q == S_WAIT) || (state_q == S_FINAL);
  assign timeout_hit = in_watch && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // The watchdog restarts on every state change so WAIT and FINAL each get a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      error    <= 1'b0;
    end else begin
      if (!in_watch || state_d != state_q) to_cnt_q <= '0;
      else                                 to_cnt_q <= to_cnt_q + TO_W'(1);
      if (timeout_hit)  error <= 1'b1;
      else if (accept)  error <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
    state_d        = state_q;
    crst_cnt_d     = crst_cnt_q;
    word_cnt_d     = word_cnt_q;
    last_d         = last_q;
    seen_busy_d    = seen_busy_q;
    core_data_d    = core_data;
    digest_d       = digest;
    digest_words_d = digest_words;

    case (state_q)
      S_CRST: begin
        if (crst_cnt_q == 2'd1) state_d    = S_IDLE;
        else                    crst_cnt_d = crst_cnt_q + 2'd1;
      end
      S_IDLE: begin
        if (accept) begin
          core_data_d = msg_data;
          last_d      = msg_last;
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
          state_d     = S_STROBE;
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        // core_data is still driven here: the core loads its permutation on this edge.
        seen_busy_d = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (core_busy) seen_busy_d = 1'b1;
        if (seen_busy_q && !core_busy) state_d = last_q ? S_FINAL : S_IDLE;
      end
      S_FINAL: begin
        if (core_end_hash) begin
          digest_d       = core_digest;
          digest_words_d = word_cnt_q;
          state_d        = S_OUT;
        end
      end
      S_OUT: begin
        if (digest_ready) state_d = S_CRST;
      end
      default: state_d = S_CRST;
    endcase

    if (timeout_hit) state_d = S_CRST;

    // Any entry into CRST discards the message in progress and re-arms the core.
    if (state_d == S_CRST && state_q != S_CRST) begin
      crst_cnt_d = '0;
      word_cnt_d = '0;
      last_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_CRST;
      crst_cnt_q      <= '0;
      word_cnt_q      <= '0;
      last_q          <= 1'b0;
      seen_busy_q     <= 1'b0;
      msg_ready       <= 1'b0;
      core_rst        <= 1'b1;
      core_data       <= '0;
      core_data_ready <= 1'b0;
      core_start_hash <= 1'b0;
      digest          <= '0;
      digest_words    <= '0;
      digest_valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q         <= state_d;
      crst_cnt_q      <= crst_cnt_d;
      word_cnt_q      <= word_cnt_d;
      last_q          <= last_d;
      seen_busy_q     <= seen_busy_d;
      core_data       <= core_data_d;
      digest          <= digest_d;
      digest_words    <= digest_words_d;
      msg_ready       <= (state_d == S_IDLE) && !core_busy;
      core_rst        <= (state_d == S_CRST);
      core_data_ready <= (state_d == S_STROBE);
      core_start_hash <= (state_d == S_FINAL);
      digest_valid    <= (state_d == S_OUT);
    end
  end

endmodule

// File: tb/tb_spongent_feeder.sv
// Self-checking bench for spongent_feeder: behavioural core model, table-driven messages,
// directed reset/stall/watchdog sequences and randomized messages against a fold reference.
`timescale 1ns/1ps
module tb_spongent_feeder;
  localparam int N       = 256;
  localparam int R       = 16;
  localparam int CNT_W   = 16;
  localparam int TO      = 100;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [N-1:0] ACC_INIT = {8{32'h6a09e667}};

  logic clk = 1'b0;
  logic rst;
  logic [R-1:0] msg_data;
  logic msg_valid, msg_last, msg_ready;
  logic core_rst, core_data_ready, core_start_hash;
  logic [R-1:0] core_data;
  logic core_busy;
  logic core_end_hash = 1'b0;
  logic [N-1:0] core_digest = '0;
  logic [N-1:0] digest;
  logic [CNT_W-1:0] digest_words;
  logic digest_valid, digest_ready, error;

  always #5 clk = ~clk;

  spongent_feeder #(.N(N), .r(R), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .core_rst(core_rst), .core_data(core_data), .core_data_ready(core_data_ready),
    .core_start_hash(core_start_hash), .core_busy(core_busy), .core_end_hash(core_end_hash),
    .core_digest(core_digest),
    .digest(digest), .digest_words(digest_words), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .error(error)
  );

  // Stand-in hash function: order-sensitive fold over the absorbed words.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction
  function automatic logic [N-1:0] mix(input logic [N-1:0] a, input logic [R-1:0] w);
    return rotl(a, 17) ^ N'(w) ^ (N'(w) << 131);
  endfunction
  function automatic logic [N-1:0] fin(input logic [N-1:0] a);
    return rotl(a, 128) ^ {8{32'h9e3779b9}};
  endfunction
  function automatic logic [N-1:0] ref_digest(input logic [R-1:0] w[$]);
    logic [N-1:0] a;
    a = ACC_INIT;
    foreach (w[i]) a = mix(a, w[i]);
    return fin(a);
  endfunction

  // Core model: loads the word on the edge after data_ready, busy for perm_lat cycles,
  // hashing takes 2*perm_lat cycles, end_hash/digest held until core_rst.
  int perm_lat = 3;
  bit hang = 1'b0;
  logic pend = 1'b0;
  int busy_cnt = 0;
  bit hashing = 1'b0;
  int hash_cnt = 0;
  logic [N-1:0] acc = ACC_INIT;

  always @(posedge clk) begin
    if (core_rst) begin
      pend <= 1'b0; busy_cnt <= 0; hashing <= 1'b0; hash_cnt <= 0;
      acc <= ACC_INIT; core_end_hash <= 1'b0; core_digest <= '0;
    end else begin
      pend <= core_data_ready;
      if (pend) begin
        acc <= mix(acc, core_data);
        busy_cnt <= perm_lat;
      end else if (busy_cnt != 0 && !hang) busy_cnt <= busy_cnt - 1;
      if (hashing) begin
        if (hash_cnt <= 1) begin
          hashing <= 1'b0; core_end_hash <= 1'b1; core_digest <= fin(acc);
        end else hash_cnt <= hash_cnt - 1;
      end else if (core_start_hash && !core_end_hash) begin
        hashing <= 1'b1; hash_cnt <= 2 * perm_lat;
      end
    end
  end
  assign core_busy = (busy_cnt != 0) || hashing;

  int ready_cycles = 0;
  int ready_busy = 0;
  always @(negedge clk) begin
    if (msg_ready === 1'b1) ready_cycles <= ready_cycles + 1;
    if (msg_ready === 1'b1 && core_busy === 1'b1) ready_busy <= ready_busy + 1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bail(input string name);
    n_checks++;
    $display("FAIL %s: no response within cycle budget", name);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (msg_ready === 1'b1) return;
    end
    bail({tag, "_ready_timeout"});
  endtask

  task automatic wait_busy(input string tag);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (core_busy === 1'b1) return;
    end
    bail({tag, "_busy_timeout"});
  endtask

  task automatic run_msg(input logic [R-1:0] w[$], input bit hold, input int stall,
                         input int exp_words, input int exp_ready, input string tag);
    logic [N-1:0] exp_dig, snap_d;
    logic [CNT_W-1:0] snap_w;
    int rc0, rb0;
    bit ok, got;
    logic dv1, c1, c2, c3, r3;
    exp_dig = ref_digest(w);
    @(posedge clk); #1;
    rc0 = ready_cycles;
    rb0 = ready_busy;
    foreach (w[i]) begin
      if (!hold) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1;
      end
      msg_valid = 1'b1;
      msg_data  = w[i];
      msg_last  = (i == w.size() - 1);
      wait_ready(tag);
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      got = (digest_valid === 1'b1);
    end
    if (!got) bail({tag, "_digest_timeout"});
    check({tag, "_digest"}, digest, exp_dig);
    check({tag, "_words"}, digest_words, exp_words);
    snap_d = digest;
    snap_w = digest_words;
    ok = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (digest !== snap_d || digest_words !== snap_w || digest_valid !== 1'b1 ||
          msg_ready !== 1'b0 || core_rst !== 1'b0) ok = 1'b0;
    end
    if (stall > 0) check({tag, "_hold"}, ok, 1);
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
    if (exp_ready >= 0) check({tag, "_ready_pulses"}, ready_cycles - rc0, exp_ready);
    check({tag, "_ready_while_busy"}, ready_busy - rb0, 0);
    @(negedge clk); dv1 = digest_valid; c1 = core_rst;
    @(negedge clk); c2 = core_rst;
    @(negedge clk); c3 = core_rst; r3 = msg_ready;
    // digest_valid drops, core_rst high for two cycles, then the feeder is ready again.
    check({tag, "_rearm"}, {dv1, c1, c2, c3, r3}, 5'b01101);
  endtask

  typedef struct {
    int         len;
    logic [R-1:0] w [4];
    bit         hold;
    int         stall;
    int         exp_words;
    int         exp_ready;
  } vec_t;
  vec_t vecs [5];

  task automatic set_vec(input int i, input int len, input logic [R-1:0] w0, input logic [R-1:0] w1,
                         input logic [R-1:0] w2, input logic [R-1:0] w3, input bit hold,
                         input int stall, input int exp_words, input int exp_ready);
    vecs[i].len = len;
    vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
    vecs[i].hold = hold; vecs[i].stall = stall;
    vecs[i].exp_words = exp_words; vecs[i].exp_ready = exp_ready;
  endtask

  initial begin
    logic [R-1:0] q[$];
    int len, ew;
    bit hold;
    logic c1, c2, r2;

    set_vec(0, 1, 16'h0000, 16'h0,    16'h0,    16'h0,    1'b1, 0,  1, 1);
    set_vec(1, 4, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b1, 50, 4, 4);
    set_vec(2, 1, 16'h6162, 16'h0,    16'h0,    16'h0,    1'b1, 0,  1, 1);
    set_vec(3, 2, 16'h6162, 16'h6364, 16'h0,    16'h0,    1'b1, 1,  2, 2);
    set_vec(4, 3, 16'hffff, 16'h8000, 16'h0001, 16'h0,    1'b0, 3,  3, -1);

    rst = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; digest_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_ctrl", {core_rst, msg_ready, core_data_ready, core_start_hash, digest_valid, error},
          6'b100000);
    check("reset_core_data", core_data, 0);
    check("reset_digest", digest, 0);
    check("reset_words", digest_words, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk); c1 = core_rst;
    @(negedge clk); c2 = core_rst; r2 = msg_ready;
    check("startup_crst", {c1, c2, r2}, 3'b101);

    for (int i = 0; i < 5; i++) begin
      q = {};
      for (int j = 0; j < vecs[i].len; j++) q.push_back(vecs[i].w[j]);
      perm_lat = 2 + i;
      run_msg(q, vecs[i].hold, vecs[i].stall, vecs[i].exp_words, vecs[i].exp_ready,
              $sformatf("vec%0d", i));
    end

    // Asynchronous reset while the core is permuting a word.
    @(posedge clk); #1;
    perm_lat = 30;
    msg_valid = 1'b1; msg_data = 16'hbeef; msg_last = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk); #1;
    msg_valid = 1'b0; msg_last = 1'b0;
    wait_busy("rst_mid");
    rst = 1'b0;
    #1;
    check("rst_mid_ctrl", {core_rst, msg_ready, core_data_ready, core_start_hash, digest_valid, error},
          6'b100000);
    check("rst_mid_core_data", core_data, 0);
    check("rst_mid_digest", digest, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    perm_lat = 4;
    q = {16'h1234, 16'h5678};
    run_msg(q, 1'b1, 0, 2, 2, "after_rst");

`ifdef SPONGENT_FEEDER_TIMEOUT_EN
    begin
      int k;
      bit saw_dv;
      @(posedge clk); #1;
      hang = 1'b1;
      msg_valid = 1'b1; msg_data = 16'h0bad; msg_last = 1'b0;
      wait_ready("wdog");
      @(posedge clk); #1;
      msg_valid = 1'b0;
      wait_busy("wdog");
      k = 1;
      saw_dv = 1'b0;
      while (error !== 1'b1 && k < 400) begin
        @(negedge clk);
        k++;
        saw_dv |= (digest_valid === 1'b1);
      end
      // error registers on the edge that closes the TO-th WAIT cycle.
      check("wdog_cycle", k, TO + 1);
      check("wdog_core_rst", core_rst, 1);
      check("wdog_no_digest", saw_dv, 0);
      hang = 1'b0;
      repeat (3) @(negedge clk);
      check("wdog_error_held", {error, core_rst}, 2'b10);
      q = {16'h6162};
      run_msg(q, 1'b1, 0, 1, 1, "wdog_next");
      check("wdog_error_cleared", error, 0);
    end
`endif

    for (int m = 0; m < 8; m++) begin
      len = $urandom_range(6, 1);
      hold = 1'($urandom_range(1, 0));
      q = {};
      for (int j = 0; j < len; j++) q.push_back(R'($urandom));
      perm_lat = $urandom_range(8, 1);
      ew = (len > CNT_MAX) ? CNT_MAX : len;
      run_msg(q, hold, $urandom_range(4, 0), ew, hold ? len : -1, $sformatf("rand%0d", m));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spongent_feeder.md
Name: spongent_feeder

Overview:
- Initiator-side driver for the iterative SPONGENT hash core.
- Accepts a message as a valid/ready stream of r-bit words and runs the core's absorb handshake per word.
- Issues start_hash after the last word, captures the digest, and presents it on a valid/ready output.
- Re-arms the core with a reset pulse between messages, so the hash datapath runs back-to-back without software sequencing.

Parameters:
N, 256, digest width in bits
r, 16, rate / message word width in bits (8 or 16)
CNT_W, 16, width of message word counter
TIMEOUT_CYCLES, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
msg_data  in  r  message word
msg_valid  in  1  msg_data valid
msg_last  in  1  word is the final one of the message
msg_ready  out  1  word accepted when msg_valid & msg_ready
core_rst  out  1  synchronous active-high reset to core
core_data  out  r  to core data_input
core_data_ready  out  1  to core data_ready
core_start_hash  out  1  to core start_hash
core_busy  in  1  from core busy
core_end_hash  in  1  from core end_hash
core_digest  in  N  from core digest
digest  out  N  captured digest
digest_words  out  CNT_W  number of words in hashed message
digest_valid  out  1  digest/digest_words valid
digest_ready  in  1  consumer accepts digest
error  out  1  watchdog abort flag (tied 0 without the optional feature)

Behaviour:
- Reset values (rst=0, async): state=CRST, core_rst=1, msg_ready=0, core_data=0, core_data_ready=0, core_start_hash=0, digest=0, digest_words=0, digest_valid=0, error=0, word counter=0, last flag=0, seen_busy=0.
- All outputs are registered. Reset mid-message discards the message; core_rst stays high until the FSM leaves CRST.
- FSM states and transitions:
  - CRST: core_rst=1 for exactly 2 cycles (2-bit counter), then IDLE.
  - IDLE: msg_ready = (core_busy==0). On a handshake: core_data<=msg_data, last<=msg_last, counter+=1 (saturates at all-ones), go STROBE.
  - STROBE: core_data_ready=1 for 1 cycle, then HOLD.
  - HOLD: core_data_ready=0. core_data stays stable through this cycle (the core loads the permutation on this edge). Clear seen_busy, go WAIT.
  - WAIT: set seen_busy when core_busy=1. Exit only when seen_busy=1 and core_busy=0: go FINAL if last=1, else IDLE.
  - FINAL: core_start_hash=1, held until core_end_hash=1 is sampled. On that cycle: digest<=core_digest, digest_words<=counter, go OUT.
  - OUT: core_start_hash=0, digest_valid=1. On digest_ready: digest_valid=0, counter=0, go CRST.
- msg_ready is never asserted outside IDLE, so only one word is in flight.
- Minimum latency per absorbed word = 3 + core permutation time.
- Messages are ≥1 word. Padding is done by the core (an extra block of 1 followed by zeros).
- msg_last on the first word yields a 1-word message.
- digest_valid held with digest_ready=0: digest stable, no new msg_ready.
- core_end_hash outside FINAL is ignored.

Optional Feature:
SPONGENT_FEEDER_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT and FINAL and clears on each state entry.
  - Reaching TIMEOUT_CYCLES: error<=1, discard the message, go CRST.
  - error stays high until the next accepted msg word.
- Undefined: no counter; error tied 0; WAIT/FINAL wait indefinitely.

Test Plan:
- Single word 0x0000 with msg_last=1 (N=256, r=16) -> one STROBE, then core_start_hash until end_hash. digest_valid=1 with digest_words=1, digest equal to the golden SPONGENT-256 of the 2-byte zero message.
- 4 words 0x0102,0x0304,0x0506,0x0708 with msg_valid held continuously -> msg_ready pulses exactly 4 times, each only while core_busy=0. digest_words=4, digest matches the golden model.
- digest_ready held 0 for 50 cycles -> digest and digest_valid stable, msg_ready=0, core_rst=0. After digest_ready=1 -> core_rst high 2 cycles, then msg_ready=1.
- Two messages back-to-back ("ab", then "abcd") -> second digest independent of the first and matching the golden model; digest_words=1 then 2.
- Async rst low mid-WAIT -> all outputs to reset values immediately, core_rst=1; after release, the next message hashes correctly.
- With SPONGENT_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=100, core model holds busy=1 forever -> error=1 at cycle 100 of WAIT, core_rst pulse, no digest_valid. error clears on the next accepted word.
